hybrid_branch_predict: RTL and testbench

// - Parametrised successor to the local two-level predictor. Adds a gshare global-history table, a per-PC

---
 rtl/hybrid_branch_predict.sv | 110 +++++++++++
 tb/tb_hybrid_branch_predict.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hybrid_branch_predict.sv
// Hybrid branch predictor: local two-level, gshare and per-PC tournament chooser.
// Lookup on PcF2 is registered into D; training happens from E with non-speculative history.
module hybrid_branch_predict #(
    parameter int unsigned MODE       = 2,
    parameter int unsigned BHT_DEPTH  = 10,
    parameter int unsigned HIST_W     = 6,
    parameter int unsigned GHR_W      = 8,
    parameter int unsigned CPHT_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flushD,
    input  logic        stallD,
    input  logic [31:0] instrD,
    input  logic [31:0] PcF2,
    input  logic [31:0] pcE,
    input  logic        branchE,
    input  logic        actual_takeE,
    output logic        branchD,
    output logic        pred_takeD,
    output logic        pred_globalD
);

    localparam int unsigned BhtN  = 1 << BHT_DEPTH;
    localparam int unsigned LphtN = 1 << HIST_W;
    localparam int unsigned GphtN = 1 << GHR_W;
    localparam int unsigned CphtN = 1 << CPHT_DEPTH;

    function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
        if (up) return (c == 2'b11) ? c : c + 2'd1;
        else    return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    logic [HIST_W-1:0] bht_q  [BhtN];
    logic [1:0]        lpht_q [LphtN];
    logic [1:0]        gpht_q [GphtN];
    logic [1:0]        cpht_q [CphtN];
    logic [GHR_W-1:0]  ghr_q;
    logic              pred_q, sel_q;

    logic [5:0] opcode;
    assign opcode  = instrD[31:26];
    assign branchD = (opcode == 6'b000001 && instrD[19:18] == 2'b00) || (opcode[5:2] == 4'b0001);

    // Fetch-side lookup
    logic [BHT_DEPTH-1:0]  bidx_f, bidx_e;
    logic [HIST_W-1:0]     lidx_f, lidx_e;
    logic [GHR_W-1:0]      gidx_f, gidx_e;
    logic [CPHT_DEPTH-1:0] cidx_f, cidx_e;
    logic                  pl_f, pg_f, sel_f, pred_f;
    logic                  pl_e, pg_e;

    assign bidx_f = PcF2[BHT_DEPTH+1:2];
    assign lidx_f = bht_q[bidx_f];
    assign gidx_f = ghr_q ^ PcF2[GHR_W+1:2];
    assign cidx_f = PcF2[CPHT_DEPTH+1:2];
    assign pl_f   = lpht_q[lidx_f][1];
    assign pg_f   = gpht_q[gidx_f][1];

    always_comb begin
        sel_f = 1'b0;
        if (MODE == 1)      sel_f = 1'b1;
        else if (MODE == 2) sel_f = cpht_q[cidx_f][1];
        pred_f = sel_f ? pg_f : pl_f;
    end

    // Execute-side indices use pre-shift history
    assign bidx_e = pcE[BHT_DEPTH+1:2];
    assign lidx_e = bht_q[bidx_e];
    assign gidx_e = ghr_q ^ pcE[GHR_W+1:2];
    assign cidx_e = pcE[CPHT_DEPTH+1:2];
    assign pl_e   = lpht_q[lidx_e][1];
    assign pg_e   = gpht_q[gidx_e][1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BhtN; i++)  bht_q[i]  <= '0;
            for (int i = 0; i < LphtN; i++) lpht_q[i] <= 2'b01;
            for (int i = 0; i < GphtN; i++) gpht_q[i] <= 2'b01;
            for (int i = 0; i < CphtN; i++) cpht_q[i] <= 2'b01;
            ghr_q <= '0;
        end else if (branchE) begin
            lpht_q[lidx_e] <= sat_step(lpht_q[lidx_e], actual_takeE);
            gpht_q[gidx_e] <= sat_step(gpht_q[gidx_e], actual_takeE);
            // Chooser trains toward whichever table was right when they disagree
            if (MODE == 2 && pl_e != pg_e) begin
                cpht_q[cidx_e] <= sat_step(cpht_q[cidx_e], pg_e == actual_takeE);
            end
            bht_q[bidx_e] <= {bht_q[bidx_e][HIST_W-2:0], actual_takeE};
            ghr_q         <= {ghr_q[GHR_W-2:0], actual_takeE};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flushD) begin
            pred_q <= 1'b0;
            sel_q  <= 1'b0;
        end else if (!stallD) begin
            pred_q <= pred_f;
            sel_q  <= sel_f;
        end
    end

    assign pred_takeD   = branchD & pred_q;
    assign pred_globalD = branchD & sel_q;

    logic unused_bits;
    assign unused_bits = ^{instrD, PcF2, pcE};

endmodule

// File: tb/tb_hybrid_branch_predict.sv
// Bench for hybrid_branch_predict: one instance per MODE driven in parallel, checked against
// an array-based reference model plus hand-written corner-case sequences.
module tb_hybrid_branch_predict;

    logic        clk = 1'b0;
    logic        rst, flushD, stallD, branchE, actual_takeE;
    logic [31:0] instrD, PcF2, pcE;
    logic        br [3];
    logic        pt [3];
    logic        pgl[3];

    always #5 clk = ~clk;

    hybrid_branch_predict #(.MODE(0)) u_m0 (
        .clk(clk), .rst(rst), .flushD(flushD), .stallD(stallD), .instrD(instrD), .PcF2(PcF2),
        .pcE(pcE), .branchE(branchE), .actual_takeE(actual_takeE),
        .branchD(br[0]), .pred_takeD(pt[0]), .pred_globalD(pgl[0]));
    hybrid_branch_predict #(.MODE(1)) u_m1 (
        .clk(clk), .rst(rst), .flushD(flushD), .stallD(stallD), .instrD(instrD), .PcF2(PcF2),
        .pcE(pcE), .branchE(branchE), .actual_takeE(actual_takeE),
        .branchD(br[1]), .pred_takeD(pt[1]), .pred_globalD(pgl[1]));
    hybrid_branch_predict #(.MODE(2)) u_m2 (
        .clk(clk), .rst(rst), .flushD(flushD), .stallD(stallD), .instrD(instrD), .PcF2(PcF2),
        .pcE(pcE), .branchE(branchE), .actual_takeE(actual_takeE),
        .branchD(br[2]), .pred_takeD(pt[2]), .pred_globalD(pgl[2]));

    // Reference model: counters as integers 0..3, histories as integers
    int m_bht [1024];
    int m_lpht[64];
    int m_gpht[256];
    int m_cpht[256];
    int m_ghr;
    int m_pred[3];
    int m_sel [3];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic        exp_br;
    } dec_vec_t;
    dec_vec_t vecs[13];

    function automatic bit is_branch(input logic [31:0] ins);
        int op;
        op = int'(ins >> 26);
        if (op == 1) return int'((ins >> 17) & 32'd7) <= 1;
        return op >= 4 && op <= 7;
    endfunction

    function automatic int sat(input int c, input bit up);
        if (up) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) m_bht[i] = 0;
        for (int i = 0; i < 64; i++)   m_lpht[i] = 1;
        for (int i = 0; i < 256; i++)  m_gpht[i] = 1;
        for (int i = 0; i < 256; i++)  m_cpht[i] = 1;
        m_ghr = 0;
        for (int m = 0; m < 3; m++) begin
            m_pred[m] = 0;
            m_sel[m]  = 0;
        end
    endtask

    task automatic model_edge();
        int f, e, bi, li, gi, ci, sel;
        bit pl, pg, ple, pge;
        if (rst) begin
            model_reset();
            return;
        end
        f  = int'(PcF2 >> 2);
        pl = m_lpht[m_bht[f % 1024]] >= 2;
        pg = m_gpht[m_ghr ^ (f % 256)] >= 2;
        for (int m = 0; m < 3; m++) begin
            sel = (m == 0) ? 0 : (m == 1) ? 1 : int'(m_cpht[f % 256] >= 2);
            if (flushD) begin
                m_pred[m] = 0;
                m_sel[m]  = 0;
            end else if (!stallD) begin
                m_pred[m] = (sel != 0) ? int'(pg) : int'(pl);
                m_sel[m]  = sel;
            end
        end
        if (branchE) begin
            e   = int'(pcE >> 2);
            bi  = e % 1024;
            li  = m_bht[bi];
            gi  = m_ghr ^ (e % 256);
            ci  = e % 256;
            ple = m_lpht[li] >= 2;
            pge = m_gpht[gi] >= 2;
            m_lpht[li] = sat(m_lpht[li], actual_takeE);
            m_gpht[gi] = sat(m_gpht[gi], actual_takeE);
            if (ple != pge) m_cpht[ci] = sat(m_cpht[ci], pge == actual_takeE);
            m_bht[bi] = (m_bht[bi] * 2 + int'(actual_takeE)) % 64;
            m_ghr     = (m_ghr * 2 + int'(actual_takeE)) % 256;
        end
    endtask

    task automatic check(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        bit b;
        b = is_branch(instrD);
        for (int m = 0; m < 3; m++) begin
            check($sformatf("%s branchD m%0d", tag, m), br[m], b);
            check($sformatf("%s pred_takeD m%0d", tag, m), pt[m], b & (m_pred[m] != 0));
            check($sformatf("%s pred_globalD m%0d", tag, m), pgl[m], b & (m_sel[m] != 0));
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic upd(input logic [31:0] pc, input logic t);
        branchE      = 1'b1;
        pcE          = pc;
        actual_takeE = t;
        step("upd");
        branchE = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc);
        PcF2 = pc;
        step("lookup");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step("reset");
        rst = 1'b0;
    endtask

    function automatic logic [31:0] pick_pc();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 8) return 32'h100 + 32'(r * 4);
        return $urandom;
    endfunction

    initial begin
        vecs[0]  = '{32'h1000_0003, 1'b1};  // beq
        vecs[1]  = '{32'h1400_0000, 1'b1};  // bne
        vecs[2]  = '{32'h1800_0000, 1'b1};  // blez
        vecs[3]  = '{32'h1C00_0000, 1'b1};  // bgtz
        vecs[4]  = '{32'h0000_0020, 1'b0};  // add
        vecs[5]  = '{32'h0400_0000, 1'b1};  // bltz
        vecs[6]  = '{32'h0401_0000, 1'b1};  // bgez
        vecs[7]  = '{32'h0402_0000, 1'b1};  // [19:17]=001
        vecs[8]  = '{32'h0404_0000, 1'b0};  // [19:17]=010
        vecs[9]  = '{32'h0410_0000, 1'b1};  // bltzal
        vecs[10] = '{32'h0406_0000, 1'b0};  // [19:17]=011
        vecs[11] = '{32'h2000_0000, 1'b0};  // addi
        vecs[12] = '{32'h0800_0000, 1'b0};  // j

        rst = 1'b1; flushD = 1'b0; stallD = 1'b0; branchE = 1'b0; actual_takeE = 1'b0;
        instrD = 32'h0; PcF2 = 32'h0; pcE = 32'h0;
        model_reset();
        step("init");
        step("init");
        rst = 1'b0;

        // Decode table; prediction registers are still clear from reset
        for (int i = 0; i < 13; i++) begin
            instrD = vecs[i].instr;
            #1;
            for (int m = 0; m < 3; m++) begin
                check($sformatf("decode[%0d] branchD m%0d", i, m), br[m], vecs[i].exp_br);
                check($sformatf("decode[%0d] pred_takeD m%0d", i, m), pt[m], 1'b0);
            end
        end

        // Reset with a branch in D: both outputs clear on the following cycle
        instrD = 32'h1000_0003;
        PcF2   = $urandom;
        do_reset();
        for (int m = 0; m < 3; m++) begin
            check($sformatf("rst pred_takeD m%0d", m), pt[m], 1'b0);
            check($sformatf("rst pred_globalD m%0d", m), pgl[m], 1'b0);
        end

        // Eight taken updates saturate LPHT[63]
        PcF2 = 32'h300;
        for (int i = 0; i < 8; i++) upd(32'h100, 1'b1);
        lookup(32'h100);
        check("s2 local trained", pt[0], 1'b1);

        // Non-branch in D masks the held prediction
        instrD = 32'h0000_0020;
        #1;
        check("s4 add branchD", br[0], 1'b0);
        check("s4 add pred_takeD", pt[0], 1'b0);
        instrD = 32'h1000_0003;
        #1;
        check("s4 beq pred_takeD", pt[0], 1'b1);

        // Stall holds; flush wins over stall
        stallD = 1'b1;
        PcF2   = 32'h300;
        step("stall");
        check("s5 stall hold", pt[0], 1'b1);
        step("stall");
        check("s5 stall hold2", pt[0], 1'b1);
        flushD = 1'b1;
        step("flush");
        check("s5 flush under stall", pt[0], 1'b0);
        flushD = 1'b0;
        stallD = 1'b0;

        // Alternating pattern learned by local history
        do_reset();
        for (int i = 0; i < 20; i++) upd(32'h200, (i % 2) == 0);
        lookup(32'h200);
        check("s3 alternation next T", pt[0], 1'b1);

        // Chooser moves toward global when only gshare was right
        do_reset();
        upd(32'h200, 1'b0);
        upd(32'h100, 1'b1);
        upd(32'h104, 1'b1);
        lookup(32'h104);
        check("s6 chooser global m2", pgl[2], 1'b1);
        check("s6 global m1", pgl[1], 1'b1);
        check("s6 global m0", pgl[0], 1'b0);
        upd(32'h104, 1'b1);  // both tables predict NT here: chooser must not move
        lookup(32'h104);
        check("s6 chooser unchanged", pgl[2], 1'b1);

        // Randomized traffic against the model, including same-cycle lookup/update
        for (int n = 0; n < 3000; n++) begin
            rst          = ($urandom_range(0, 199) == 0);
            flushD       = ($urandom_range(0, 19) == 0);
            stallD       = ($urandom_range(0, 5) == 0);
            branchE      = ($urandom_range(0, 1) == 1);
            actual_takeE = ($urandom_range(0, 3) != 0);
            PcF2         = pick_pc();
            pcE          = ($urandom_range(0, 3) == 0) ? PcF2 : pick_pc();
            instrD       = ($urandom_range(0, 1) == 1) ? vecs[$urandom_range(0, 12)].instr : $urandom;
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
